// File: rtl/descrambler_ctrl.sv
// Sequencing controller for the per-lane 66b descrambler: reset/enable/bypass drive, priming, valid qualification.
// Optional sync-header hi-BER monitor is built when DESCRAMBLER_CTRL_BER_MON_EN is defined.
module descrambler_ctrl #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int PRIME_BLOCKS    = 1,
    parameter int WINDOW_BLOCKS   = 1024,
    parameter int BER_THRESHOLD   = 16,
    parameter int NB_ERR_CNT      = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_block_lock,
    input  logic                  i_bypass_cfg,
    input  logic [1:0]            i_sync_header,
    output logic                  o_desc_reset,
    output logic                  o_desc_enable,
    output logic                  o_desc_bypass,
    output logic                  o_valid,
    output logic [1:0]            o_state,
    output logic                  o_hi_ber,
    output logic [NB_ERR_CNT-1:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [3:0] PRIME_LAST = 4'(PRIME_BLOCKS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_prime_cnt;
    logic [3:0] w_prime_cnt_next;
    logic       r_desc_reset;
    logic       r_desc_bypass;
    logic       r_valid;
    logic       w_run_blk;
    logic       w_ber_flush;

    assign w_run_blk = i_enable && (r_state == ST_RUN);

    always_comb begin
        w_state_next     = r_state;
        w_prime_cnt_next = r_prime_cnt;
        case (r_state)
            ST_IDLE: begin
                w_prime_cnt_next = '0;
                if (i_block_lock)
                    w_state_next = r_desc_bypass ? ST_RUN : ST_PRIME;
            end
            ST_PRIME: begin
                if (i_enable) begin
                    if (r_prime_cnt == PRIME_LAST) begin
                        w_state_next     = ST_RUN;
                        w_prime_cnt_next = '0;
                    end else begin
                        w_prime_cnt_next = r_prime_cnt + 4'd1;
                    end
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Lock loss and a hi-BER flush both dominate every other transition.
        if (!i_block_lock || w_ber_flush) begin
            w_state_next     = ST_IDLE;
            w_prime_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_prime_cnt   <= '0;
            r_desc_reset  <= 1'b1;
            r_desc_bypass <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_prime_cnt  <= w_prime_cnt_next;
            r_desc_reset <= (w_state_next == ST_IDLE);
            if (r_state == ST_IDLE)
                r_desc_bypass <= i_bypass_cfg;
            r_valid <= w_run_blk;
        end
    end

    assign o_desc_reset  = r_desc_reset;
    assign o_desc_enable = i_enable && (r_state != ST_IDLE);
    assign o_desc_bypass = r_desc_bypass;
    assign o_valid       = r_valid;
    assign o_state       = r_state;

`ifdef DESCRAMBLER_CTRL_BER_MON_EN
    localparam int                WIN_W    = $clog2(WINDOW_BLOCKS);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_BLOCKS - 1);

    logic [WIN_W-1:0]      r_win_cnt;
    logic [NB_ERR_CNT-1:0] r_err_cnt;
    logic [NB_ERR_CNT-1:0] w_err_sum;
    logic                  r_hi_ber;
    logic                  w_hdr_bad;
    logic                  w_win_end;

    assign w_hdr_bad = (i_sync_header == 2'b00) || (i_sync_header == 2'b11);
    // The current block's error is folded in before the threshold compare.
    assign w_err_sum = (w_hdr_bad && (r_err_cnt != {NB_ERR_CNT{1'b1}}))
                     ? r_err_cnt + NB_ERR_CNT'(1) : r_err_cnt;
    assign w_ber_flush = w_run_blk && (int'(w_err_sum) >= BER_THRESHOLD);
    assign w_win_end   = w_run_blk && (r_win_cnt == WIN_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (w_ber_flush) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b1;
        end else if (w_state_next == ST_IDLE) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (w_run_blk) begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
            r_err_cnt <= w_err_sum;
        end
    end

    assign o_hi_ber    = r_hi_ber;
    assign o_err_count = r_err_cnt;
`else
    assign w_ber_flush = 1'b0;
    assign o_hi_ber    = 1'b0;
    assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_descrambler_ctrl.sv
// Scoreboard bench for descrambler_ctrl: directed per-cycle vectors push expectations, a monitor pops and compares.
module tb_descrambler_ctrl;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       lock;
    logic       bcfg;
    logic [1:0] hdr;
    logic       desc_reset, desc_enable, desc_bypass, valid, hi_ber;
    logic [1:0] state;
    logic [7:0] err_count;

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic       rst;
        logic       den;
        logic       byp;
        logic       val;
        logic       hib;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    descrambler_ctrl #(
        .LEN_CODED_BLOCK(66),
        .PRIME_BLOCKS   (1),
        .WINDOW_BLOCKS  (64),
        .BER_THRESHOLD  (4),
        .NB_ERR_CNT     (8)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (enable),
        .i_block_lock (lock),
        .i_bypass_cfg (bcfg),
        .i_sync_header(hdr),
        .o_desc_reset (desc_reset),
        .o_desc_enable(desc_enable),
        .o_desc_bypass(desc_bypass),
        .o_valid      (valid),
        .o_state      (state),
        .o_hi_ber     (hi_ber),
        .o_err_count  (err_count)
    );

    // Drive one cycle of inputs and queue the outputs expected just after the next edge.
    task automatic step(input string nm, input logic r, input logic lk, input logic en,
                        input logic bc, input logic [1:0] e_st, input logic e_byp,
                        input logic e_val, input logic [1:0] h = 2'b01,
                        input logic e_hib = 1'b0, input logic [7:0] e_err = 8'd0);
        exp_t e;
        @(negedge clk);
        rst    = r;
        lock   = lk;
        enable = en;
        bcfg   = bc;
        hdr    = h;
        e.nm  = nm;
        e.st  = e_st;
        e.rst = (e_st == IDLE);
        e.den = en && (e_st != IDLE);
        e.byp = e_byp;
        e.val = e_val;
        e.hib = e_hib;
        e.err = e_err;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (state !== e.st || desc_reset !== e.rst || desc_enable !== e.den ||
                    desc_bypass !== e.byp || valid !== e.val || hi_ber !== e.hib ||
                    err_count !== e.err) begin
                    n_miss++;
                    $display("FAIL %s: got st=%0d rst=%b den=%b byp=%b val=%b hib=%b err=%0d, exp st=%0d rst=%b den=%b byp=%b val=%b hib=%b err=%0d",
                             e.nm, state, desc_reset, desc_enable, desc_bypass, valid, hi_ber, err_count,
                             e.st, e.rst, e.den, e.byp, e.val, e.hib, e.err);
                end else begin
                    $display("vec %0d %s: st=%0d val=%b hib=%b err=%0d ok", n_vec, e.nm, state, valid, hi_ber, err_count);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        logic bad;
        rst = 1'b1; lock = 1'b0; enable = 1'b0; bcfg = 1'b0; hdr = 2'b01;

        step("reset0", 1, 0, 0, 0, IDLE, 0, 0);
        step("reset1", 1, 0, 1, 0, IDLE, 0, 0);
        step("idle",   0, 0, 1, 0, IDLE, 0, 0);

        // Lock rise, one discarded prime block, then valid from the third cycle after lock.
        step("lock_rise", 0, 1, 1, 0, PRIME, 0, 0);
        step("prime_blk", 0, 1, 1, 0, RUN,   0, 0);
        step("run_1",     0, 1, 1, 0, RUN,   0, 1);
        step("run_2",     0, 1, 1, 0, RUN,   0, 1);

        // Lock loss mid-stream and re-prime.
        step("lock_loss", 0, 0, 1, 0, IDLE,  0, 1);
        step("idle_lost", 0, 0, 1, 0, IDLE,  0, 0);
        step("relock",    0, 1, 1, 0, PRIME, 0, 0);
        step("reprime",   0, 1, 1, 0, RUN,   0, 0);
        step("rerun",     0, 1, 1, 0, RUN,   0, 1);

        // Sparse enable: one strobe every third cycle.
        step("drop_sp",   0, 0, 0, 0, IDLE, 0, 0);
        step("idle_sp",   0, 0, 0, 0, IDLE, 0, 0);
        for (int i = 1; i <= 9; i++)
            step("sparse", 0, 1, (i % 3 == 0), 0, (i < 3) ? PRIME : RUN, 0,
                 (i % 3 == 0) && (i > 3));

        // Bypass: loaded only in IDLE, goes straight to RUN, ignores cfg changes afterwards.
        step("drop_byp",  0, 0, 0, 1, IDLE, 0, 0);
        step("load_byp",  0, 0, 0, 1, IDLE, 1, 0);
        step("lock_byp",  0, 1, 1, 1, RUN,  1, 0);
        step("run_byp1",  0, 1, 1, 0, RUN,  1, 1);
        step("run_byp2",  0, 1, 1, 0, RUN,  1, 1);
        step("loss_byp",  0, 0, 1, 0, IDLE, 1, 1);
        step("clr_byp",   0, 0, 0, 0, IDLE, 0, 0);

        step("relock2",   0, 1, 1, 0, PRIME, 0, 0);
        step("reprime2",  0, 1, 1, 0, RUN,   0, 0);

`ifdef DESCRAMBLER_CTRL_BER_MON_EN
        // Four bad headers trip hi-BER and flush to IDLE.
        for (int i = 1; i <= 3; i++)
            step("ber_err", 0, 1, 1, 0, RUN, 0, 1, 2'b11, 0, 8'(i));
        step("ber_trip",    0, 1, 1, 0, IDLE,  0, 1, 2'b11, 1, 8'd0);
        step("ber_reprime", 0, 1, 1, 0, PRIME, 0, 0, 2'b01, 1, 8'd0);
        step("ber_rerun",   0, 1, 1, 0, RUN,   0, 0, 2'b01, 1, 8'd0);
        // A clean 64-block window clears hi-BER on its last block.
        for (int i = 1; i <= 64; i++)
            step("win_clean", 0, 1, 1, 0, RUN, 0, 1, 2'b01, (i != 64), 8'd0);

        // Errors at 10, 20, 30 and on the 64th block: counted before compare, so it trips.
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            bad = ((i % 10 == 0) && (i <= 30)) || (i == 64);
            if (i == 64)
                step("win_edge_trip", 0, 1, 1, 0, IDLE, 0, 1, 2'b11, 1, 8'd0);
            else begin
                if (bad) n++;
                step("win_edge", 0, 1, 1, 0, RUN, 0, 1, bad ? 2'b11 : 2'b10, 0, 8'(n));
            end
        end
        step("edge_reprime", 0, 1, 1, 0, PRIME, 0, 0, 2'b01, 1, 8'd0);
        step("edge_rerun",   0, 1, 1, 0, RUN,   0, 0, 2'b01, 1, 8'd0);

        // Three errors only, plus an ignored gap cycle with a bad header: window clears.
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            if (i == 6)
                step("win_gap", 0, 1, 0, 0, RUN, 0, 0, 2'b00, 1, 8'(n));
            bad = (i % 10 == 0) && (i <= 30);
            if (bad) n++;
            step("win_three", 0, 1, 1, 0, RUN, 0, 1, bad ? 2'b00 : 2'b01,
                 (i != 64), (i == 64) ? 8'd0 : 8'(n));
        end
`else
        for (int i = 1; i <= 3; i++)
            step("no_monitor", 0, 1, 1, 0, RUN, 0, 1, 2'b11, 0, 8'd0);
`endif

        // Reset mid-operation overrides RUN.
        step("mid_reset", 1, 1, 1, 1, IDLE, 0, 0);
        step("post_reset", 0, 0, 0, 0, IDLE, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, exp 0 pending", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
